ar_fifo_unpacker: RTL and testbench

Downstream drain stage for the team's SRL FIFO: pops wide words through the FIFO's DEQ/EMPTY_N show-ahead interface and serialises each into narrow lanes on a valid/ready output. It sits between a 128-bit FIFO and narrower consumers such as 32-bit worker ports. Optionally it tracks message length and flags end-of-message.

---
 rtl/ar_pkg.sv | 25 ++
 rtl/ar_fifo_unpacker_if.sv | 33 +++
 rtl/ar_msg_counter.sv | 56 +++++
 rtl/ar_fifo_unpacker.sv | 104 ++++++++++
 tb/tb_ar_fifo_unpacker.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ar_pkg.sv
// Shared constants and types for ar_fifo_unpacker: lane-ratio helpers, lane index and state types.
package ar_pkg;

   localparam int unsigned IWIDTH_DEF = 128;
   localparam int unsigned OWIDTH_DEF = 32;

   function automatic int unsigned ratio_f(input int unsigned iw, input int unsigned ow);
      return iw / ow;
   endfunction

   // A ratio of 1 would collapse the lane index to zero bits; keep at least one.
   function automatic int unsigned lane_w_f(input int unsigned iw, input int unsigned ow);
      return (iw / ow > 1) ? $clog2(iw / ow) : 1;
   endfunction

   localparam int unsigned LANE_W_DEF = lane_w_f(IWIDTH_DEF, OWIDTH_DEF);

   typedef logic [LANE_W_DEF-1:0] lane_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } state_e;

endpackage

// File: rtl/ar_fifo_unpacker_if.sv
// FIFO-side (DEQ/EMPTY_N show-ahead) and consumer-side (valid/ready) signals of the unpacker.
// Output handshake: a lane transfers in any cycle where O_VALID && O_READY; while
// O_VALID=1 and O_READY=0 the producer holds O_DATA/O_LANE/O_EOM stable.
interface ar_fifo_unpacker_if
   import ar_pkg::*;
#(
   parameter int unsigned iwidth = 128,
   parameter int unsigned owidth = 32,
   parameter int unsigned lwidth = 16
);
   localparam int unsigned LANE_W = lane_w_f(iwidth, owidth);

   logic              F_EMPTY_N;
   logic [iwidth-1:0] F_DATA;
   logic              F_DEQ;
   logic              O_VALID;
   logic              O_READY;
   logic [owidth-1:0] O_DATA;
   logic [LANE_W-1:0] O_LANE;
   logic [lwidth-1:0] MSG_LEN;
   logic              O_EOM;

   modport slave (
      input  F_EMPTY_N, F_DATA, O_READY, MSG_LEN,
      output F_DEQ, O_VALID, O_DATA, O_LANE, O_EOM
   );

   modport master (
      output F_EMPTY_N, F_DATA, O_READY, MSG_LEN,
      input  F_DEQ, O_VALID, O_DATA, O_LANE, O_EOM
   );

endinterface

// File: rtl/ar_msg_counter.sv
// Message-length tracker: samples MSG_LEN on a message's first accepted narrow word and
// flags the last word (EOM). Only built when AR_UNPACK_MSGLEN_EN is defined.
module ar_msg_counter #(
   parameter int unsigned lwidth = 16
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              CLR,
   input  logic              valid_i,
   input  logic              accept_i,
   input  logic [lwidth-1:0] msg_len_i,
   output logic              eom_o
);

   logic [lwidth-1:0] len_q, len_d;
   logic [lwidth-1:0] cnt_q, cnt_d;
   logic [lwidth-1:0] eff_len;
   logic              first_word;

   assign first_word = (cnt_q == '0);

   // The first word of a message uses the live MSG_LEN so a 1-word message can flag EOM at once.
   always_comb begin
      eff_len = len_q;
      if (first_word) begin
         eff_len = (msg_len_i == '0) ? lwidth'(1) : msg_len_i;
      end
   end

   assign eom_o = valid_i && (cnt_q == (eff_len - 1'b1));

   always_comb begin
      len_d = len_q;
      cnt_d = cnt_q;
      if (CLR) begin
         len_d = '0;
         cnt_d = '0;
      end else if (accept_i) begin
         if (first_word) begin
            len_d = eff_len;
         end
         cnt_d = eom_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         len_q <= '0;
         cnt_q <= '0;
      end else begin
         len_q <= len_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ar_fifo_unpacker.sv
// Drains wide words from a show-ahead FIFO and emits them LS lane first on valid/ready.
// Optional message-length / end-of-message tracking is enabled by AR_UNPACK_MSGLEN_EN.
module ar_fifo_unpacker
   import ar_pkg::*;
#(
   parameter int unsigned iwidth = 128,
   parameter int unsigned owidth = 32,
   parameter int unsigned lwidth = 16
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                CLR,
   ar_fifo_unpacker_if.slave   bus,
   output state_e              dbg_state_o
);

   localparam int unsigned RATIO  = ratio_f(iwidth, owidth);
   localparam int unsigned LANE_W = lane_w_f(iwidth, owidth);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

   state_e            state_q, state_d;
   logic [iwidth-1:0] hold_q, hold_d;
   logic [LANE_W-1:0] lane_q, lane_d;

   logic              o_valid;
   logic              accept;
   logic              eom;
   logic              free_hold;
   logic              deq;
   logic [owidth-1:0] o_data;

   assign o_valid   = (state_q == ST_HOLD);
   assign accept    = o_valid && bus.O_READY;
   assign free_hold = accept && ((lane_q == LAST_LANE) || eom);
   // Combinational from O_READY so the next word loads in the same cycle the last lane leaves.
   assign deq       = RST_N && !CLR && bus.F_EMPTY_N && (!o_valid || free_hold);

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      lane_d  = lane_q;
      if (CLR) begin
         state_d = ST_EMPTY;
         hold_d  = '0;
         lane_d  = '0;
      end else if (deq) begin
         state_d = ST_HOLD;
         hold_d  = bus.F_DATA;
         lane_d  = '0;
      end else if (free_hold) begin
         state_d = ST_EMPTY;
         lane_d  = '0;
      end else if (accept) begin
         lane_d  = lane_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_EMPTY;
         hold_q  <= '0;
         lane_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         lane_q  <= lane_d;
      end
   end

   always_comb begin
      o_data = '0;
      for (int unsigned i = 0; i < RATIO; i++) begin
         if (lane_q == LANE_W'(i)) begin
            o_data = hold_q[i*owidth +: owidth];
         end
      end
   end

`ifdef AR_UNPACK_MSGLEN_EN
   ar_msg_counter #(
      .lwidth (lwidth)
   ) u_msg_counter (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .CLR       (CLR),
      .valid_i   (o_valid),
      .accept_i  (accept),
      .msg_len_i (bus.MSG_LEN),
      .eom_o     (eom)
   );
`else
   logic unused_msg_len;
   assign unused_msg_len = ^bus.MSG_LEN;
   assign eom            = 1'b0;
`endif

   assign bus.F_DEQ   = deq;
   assign bus.O_VALID = o_valid;
   assign bus.O_DATA  = o_data;
   assign bus.O_LANE  = lane_q;
   assign bus.O_EOM   = eom;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ar_fifo_unpacker.sv
// Bench for ar_fifo_unpacker: queue-modelled FIFO, lane scoreboard, directed and random scenarios.
module tb_ar_fifo_unpacker;
   import ar_pkg::*;

   localparam int unsigned IW    = 128;
   localparam int unsigned OW    = 32;
   localparam int unsigned LW    = 16;
   localparam int unsigned RATIO = IW / OW;

   // ---------------- clock / reset ----------------
   logic   clk = 1'b0;
   logic   rst_n;
   logic   clr;
   state_e dbg_state;

   always #5 clk = ~clk;

   ar_fifo_unpacker_if #(.iwidth(IW), .owidth(OW), .lwidth(LW)) bus ();

   ar_fifo_unpacker #(.iwidth(IW), .owidth(OW), .lwidth(LW)) dut (
      .CLK         (clk),
      .RST_N       (rst_n),
      .CLR         (clr),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // ---------------- model state ----------------
   logic [IW-1:0]   fifo_q[$];
   logic            fifo_gate;
   logic [OW+1:0]   exp_q[$];
   int              checks = 0;
   int              errors = 0;
   int              acc_cnt = 0;
   logic            prev_stall = 1'b0;
   logic [OW-1:0]   prev_data;
   logic [1:0]      prev_lane;
   logic            exp_eom;
`ifdef AR_UNPACK_MSGLEN_EN
   int              m_left = 0;
   int              cur_left;
`endif

   // FIFO model drives the show-ahead head 1 time unit after each negedge
   always @(negedge clk) begin
      #1;
      bus.F_EMPTY_N = fifo_gate && (fifo_q.size() != 0);
      bus.F_DATA    = (fifo_q.size() != 0) ? fifo_q[0] : '0;
   end

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      logic [IW-1:0] w;
      logic [OW+1:0] e;
      #3;
      if (!rst_n || clr) begin
         exp_q.delete();
         prev_stall = 1'b0;
`ifdef AR_UNPACK_MSGLEN_EN
         m_left = 0;
`endif
      end else begin
         if (prev_stall) begin
            checks++;
            if (bus.O_VALID !== 1'b1 || bus.O_LANE !== prev_lane || bus.O_DATA !== prev_data) begin
               errors++;
               $display("FAIL stall_hold: got v=%b lane=%0d data=%h, need v=1 lane=%0d data=%h",
                        bus.O_VALID, bus.O_LANE, bus.O_DATA, prev_lane, prev_data);
            end
         end
         prev_stall = bus.O_VALID && !bus.O_READY;
         prev_lane  = bus.O_LANE;
         prev_data  = bus.O_DATA;

         if (bus.O_VALID) begin
`ifdef AR_UNPACK_MSGLEN_EN
            cur_left = (m_left == 0) ? ((bus.MSG_LEN == '0) ? 1 : int'(bus.MSG_LEN)) : m_left;
            exp_eom  = (cur_left == 1);
`else
            exp_eom  = 1'b0;
`endif
            checks++;
            if (bus.O_EOM !== exp_eom) begin
               errors++;
               $display("FAIL sb_eom: got %b need %b", bus.O_EOM, exp_eom);
            end
         end

         if (bus.O_VALID && bus.O_READY) begin
            acc_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_extra: got lane=%0d data=%h, need no output", bus.O_LANE, bus.O_DATA);
            end else begin
               e = exp_q.pop_front();
               if ({bus.O_LANE, bus.O_DATA} !== e) begin
                  errors++;
                  $display("FAIL sb_lane_data: got lane=%0d data=%h, need lane=%0d data=%h",
                           bus.O_LANE, bus.O_DATA, e[OW+1:OW], e[OW-1:0]);
               end
            end
`ifdef AR_UNPACK_MSGLEN_EN
            m_left = cur_left - 1;
            // an ended message drops the rest of its wide word
            if (exp_eom) begin
               while (exp_q.size() != 0 && exp_q[0][OW+1:OW] != 2'd0) exp_q.delete(0);
            end
`endif
         end

         if (bus.F_DEQ) begin
            checks++;
            if (!bus.F_EMPTY_N || fifo_q.size() == 0) begin
               errors++;
               $display("FAIL deq_when_empty: got F_DEQ=1 with F_EMPTY_N=%b, need F_DEQ=0", bus.F_EMPTY_N);
            end else begin
               w = fifo_q.pop_front();
               for (int i = 0; i < RATIO; i++) exp_q.push_back({2'(i), w[i*OW +: OW]});
            end
         end
      end
   end

   // ---------------- driver helpers ----------------
   function automatic logic [IW-1:0] rand_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (n < budget) begin
         @(negedge clk);
         bus.O_READY = 1'b1;
         fifo_gate   = 1'b1;
         #4;
         if (exp_q.size() == 0 && fifo_q.size() == 0 && !bus.O_VALID) break;
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending lanes, need 0", exp_q.size());
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.O_READY = 1'b1;
      fifo_q.push_back(rand_word());
      repeat (3) begin
         @(negedge clk);
         #4;
         checks++;
         if (bus.F_DEQ !== 1'b0 || bus.O_VALID !== 1'b0 || bus.O_DATA !== '0 ||
             bus.O_LANE !== '0 || bus.O_EOM !== 1'b0 || dbg_state !== ST_EMPTY) begin
            errors++;
            $display("FAIL reset_outputs: got deq=%b v=%b data=%h lane=%0d eom=%b, need all 0",
                     bus.F_DEQ, bus.O_VALID, bus.O_DATA, bus.O_LANE, bus.O_EOM);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      #4;
      checks++;
      if (bus.F_DEQ !== 1'b1 || bus.O_VALID !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got deq=%b v=%b, need deq=1 v=0", bus.F_DEQ, bus.O_VALID);
      end
      @(negedge clk);
      #4;
      checks++;
      if (bus.O_VALID !== 1'b1 || bus.O_LANE !== 2'd0) begin
         errors++;
         $display("FAIL reset_first_valid: got v=%b lane=%0d, need v=1 lane=0", bus.O_VALID, bus.O_LANE);
      end
      drain(50);
   endtask

   task automatic test_streaming();
      logic [IW-1:0] w;
      @(negedge clk);
      bus.O_READY = 1'b1;
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < RATIO; j++)
            w[j*OW +: OW] = {4'(3 - k), 4'(j), 24'($urandom_range(0, 24'hFFFFFF))};
         fifo_q.push_back(w);
      end
      #4;
      checks++;
      if (bus.F_DEQ !== 1'b1 || bus.O_VALID !== 1'b0) begin
         errors++;
         $display("FAIL stream_start: got deq=%b v=%b, need deq=1 v=0", bus.F_DEQ, bus.O_VALID);
      end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         #4;
         checks++;
         if (bus.O_VALID !== 1'b1 || bus.O_LANE !== 2'(i % 4) ||
             bus.F_DEQ !== ((i % 4 == 3) && (i != 11))) begin
            errors++;
            $display("FAIL stream_cycle%0d: got v=%b lane=%0d deq=%b, need v=1 lane=%0d deq=%b",
                     i, bus.O_VALID, bus.O_LANE, bus.F_DEQ, i % 4, (i % 4 == 3) && (i != 11));
         end
      end
      @(negedge clk);
      #4;
      checks++;
      if (bus.O_VALID !== 1'b0) begin
         errors++;
         $display("FAIL stream_end: got v=%b need v=0", bus.O_VALID);
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] pat;
      int acc;
      int n;
      pat = 4'b1001;
      acc = 0;
      n   = 0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) fifo_q.push_back(rand_word());
      while (acc < 12 && n < 100) begin
         if (n != 0) @(negedge clk);
         bus.O_READY = pat[n % 4];
         #4;
         if (bus.F_DEQ && bus.O_VALID) begin
            checks++;
            if (bus.O_LANE !== 2'd3 || !bus.O_READY) begin
               errors++;
               $display("FAIL bp_deq_lane: got deq at lane=%0d ready=%b, need lane=3 ready=1",
                        bus.O_LANE, bus.O_READY);
            end
         end
         if (bus.O_VALID && bus.O_READY) acc++;
         n++;
      end
      checks++;
      if (acc != 12) begin
         errors++;
         $display("FAIL bp_count: got %0d accepted lanes, need 12", acc);
      end
      drain(50);
   endtask

   task automatic test_starvation();
      @(negedge clk);
      bus.O_READY = 1'b1;
      fifo_q.push_back(rand_word());
      #4;
      checks++;
      if (bus.F_DEQ !== 1'b1) begin
         errors++;
         $display("FAIL starve_deq1: got %b need 1", bus.F_DEQ);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #4;
         checks++;
         if (bus.O_VALID !== 1'b1 || bus.O_LANE !== 2'(i)) begin
            errors++;
            $display("FAIL starve_lane%0d: got v=%b lane=%0d, need v=1 lane=%0d", i, bus.O_VALID, bus.O_LANE, i);
         end
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #4;
         checks++;
         if (bus.O_VALID !== 1'b0 || bus.F_DEQ !== 1'b0) begin
            errors++;
            $display("FAIL starve_idle%0d: got v=%b deq=%b, need 0 0", i, bus.O_VALID, bus.F_DEQ);
         end
      end
      @(negedge clk);
      fifo_q.push_back(rand_word());
      #4;
      checks++;
      if (bus.F_DEQ !== 1'b1 || bus.O_VALID !== 1'b0) begin
         errors++;
         $display("FAIL starve_refill: got deq=%b v=%b, need 1 0", bus.F_DEQ, bus.O_VALID);
      end
      @(negedge clk);
      #4;
      checks++;
      if (bus.O_VALID !== 1'b1 || bus.O_LANE !== 2'd0) begin
         errors++;
         $display("FAIL starve_resume: got v=%b lane=%0d, need v=1 lane=0", bus.O_VALID, bus.O_LANE);
      end
      drain(50);
   endtask

   task automatic test_clr();
      int n;
      n = 0;
      @(negedge clk);
      bus.O_READY = 1'b1;
      fifo_q.push_back(rand_word());
      fifo_q.push_back(rand_word());
      #4;
      while (!(bus.O_VALID && bus.O_LANE == 2'd1) && n < 20) begin
         @(negedge clk);
         #4;
         n++;
      end
      @(negedge clk);
      clr = 1'b1;
      bus.O_READY = 1'b0;
      #4;
      checks++;
      if (bus.O_VALID !== 1'b1 || bus.O_LANE !== 2'd2 || bus.F_DEQ !== 1'b0) begin
         errors++;
         $display("FAIL clr_cycle: got v=%b lane=%0d deq=%b, need v=1 lane=2 deq=0",
                  bus.O_VALID, bus.O_LANE, bus.F_DEQ);
      end
      @(negedge clk);
      clr = 1'b0;
      bus.O_READY = 1'b1;
      #4;
      checks++;
      if (bus.O_VALID !== 1'b0 || bus.O_LANE !== 2'd0 || bus.F_DEQ !== 1'b1 || dbg_state !== ST_EMPTY) begin
         errors++;
         $display("FAIL clr_after: got v=%b lane=%0d deq=%b, need v=0 lane=0 deq=1",
                  bus.O_VALID, bus.O_LANE, bus.F_DEQ);
      end
      @(negedge clk);
      #4;
      checks++;
      if (bus.O_VALID !== 1'b1 || bus.O_LANE !== 2'd0) begin
         errors++;
         $display("FAIL clr_next_word: got v=%b lane=%0d, need v=1 lane=0", bus.O_VALID, bus.O_LANE);
      end
      drain(50);
   endtask

   task automatic test_random();
      int start_acc;
      int words;
      start_acc = acc_cnt;
      words     = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         bus.O_READY = ($urandom_range(0, 3) != 0);
         fifo_gate   = ($urandom_range(0, 4) != 0);
         if (words < 40 && $urandom_range(0, 2) == 0) begin
            fifo_q.push_back(rand_word());
            words++;
         end
      end
      drain(400);
      checks++;
      if (acc_cnt - start_acc != words * RATIO) begin
         errors++;
         $display("FAIL random_count: got %0d lanes, need %0d", acc_cnt - start_acc, words * RATIO);
      end
   endtask

`ifdef AR_UNPACK_MSGLEN_EN
   task automatic test_msglen();
      int lanes[$];
      int eoms[$];
      int deqs[$];
      int n;
      @(negedge clk);
      clr = 1'b1;
      bus.O_READY = 1'b0;
      @(negedge clk);
      clr = 1'b0;
      bus.MSG_LEN = 16'd6;
      bus.O_READY = 1'b1;
      for (int k = 0; k < 4; k++) fifo_q.push_back(rand_word());
      n = 0;
      #4;
      while (lanes.size() < 12 && n < 60) begin
         if (bus.O_VALID && bus.O_READY) begin
            lanes.push_back(int'(bus.O_LANE));
            eoms.push_back(int'(bus.O_EOM));
            deqs.push_back(int'(bus.F_DEQ));
         end
         if (lanes.size() < 12) begin
            @(negedge clk);
            #4;
         end
         n++;
      end
      checks++;
      if (lanes.size() != 12) begin
         errors++;
         $display("FAIL msg6_count: got %0d accepts need 12", lanes.size());
      end else begin
         for (int i = 0; i < 12; i++) begin
            checks++;
            if (lanes[i] != ((i < 6) ? i % 4 : (i - 6) % 4) || eoms[i] != ((i == 5) || (i == 11))) begin
               errors++;
               $display("FAIL msg6_word%0d: got lane=%0d eom=%0d", i, lanes[i], eoms[i]);
            end
         end
         checks++;
         if (deqs[5] != 1) begin
            errors++;
            $display("FAIL msg6_deq_on_eom: got %0d need 1", deqs[5]);
         end
      end
      @(negedge clk);
      bus.MSG_LEN = 16'd0;
      for (int k = 0; k < 3; k++) fifo_q.push_back(rand_word());
      lanes.delete();
      eoms.delete();
      n = 0;
      #4;
      while (lanes.size() < 3 && n < 30) begin
         if (bus.O_VALID && bus.O_READY) begin
            lanes.push_back(int'(bus.O_LANE));
            eoms.push_back(int'(bus.O_EOM));
         end
         if (lanes.size() < 3) begin
            @(negedge clk);
            #4;
         end
         n++;
      end
      checks++;
      if (lanes.size() != 3) begin
         errors++;
         $display("FAIL msg0_count: got %0d need 3", lanes.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (lanes[i] != 0 || eoms[i] != 1) begin
               errors++;
               $display("FAIL msg0_word%0d: got lane=%0d eom=%0d need lane=0 eom=1", i, lanes[i], eoms[i]);
            end
         end
      end
      @(negedge clk);
      bus.MSG_LEN = 16'hFFFF;
      drain(50);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      rst_n         = 1'b0;
      clr           = 1'b0;
      fifo_gate     = 1'b1;
      bus.O_READY   = 1'b0;
      bus.MSG_LEN   = 16'hFFFF;
      bus.F_EMPTY_N = 1'b0;
      bus.F_DATA    = '0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_starvation();
      test_clr();
      test_random();
`ifdef AR_UNPACK_MSGLEN_EN
      test_msglen();
`endif
      test_streaming();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, need completion");
      $fatal(1, "watchdog expired");
   end

endmodule
